// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - UART-fed instruction-memory loader with CPU run/hold control
//
// Receives a 16-bit instruction count followed by that many 16-bit words
// (each sent LSB first) and writes them to instruction memory. The CPU is
// held while loading and released by the next RESET.
//
// Ports:
//   CLK            system clock
//   RESET          synchronous active-low reset
//   wait_transport active-low load request
//   rx_valid       one-cycle strobe, rx_data holds a received byte
//   rx_data        received UART byte
//   imem_we        instruction-memory write strobe (one cycle)
//   imem_addr      write address
//   imem_wdata     write data
//   cpu_run        1 = CPU runs, 0 = CPU held at PC 0
//   led_loading    1 while a load is in progress
//   err_flag       sticky overflow/timeout error
//   loaded_count   instruction count of the last load
module uart_program_loader #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              wait_transport,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_run,
  output logic              led_loading,
  output logic              err_flag,
  output logic [15:0]       loaded_count
);

  localparam logic [16:0] DEPTH17 = 17'(2 ** ADDR_W);
  localparam logic [31:0] TO_LIM  = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_RUN, S_CNT_L, S_CNT_H, S_INS_L, S_INS_H, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t      state;
  logic [7:0]  low_byte;
  logic [15:0] index;
  logic        skid_valid;
  logic [7:0]  skid_data;
  logic [31:0] to_cnt;

  // Survives RESET; starts at zero after configuration.
  logic [15:0] count_q = 16'd0;

  logic       in_valid;
  logic [7:0] in_data;
  logic       start_req;

  assign loaded_count = count_q;

  // A byte parked in the skid register takes precedence over the live input.
  assign in_valid  = skid_valid | rx_valid;
  assign in_data   = skid_valid ? skid_data : rx_data;
  assign start_req = !wait_transport &&
                     (state == S_RUN || state == S_DONE || state == S_ERR);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= S_RUN;
      cpu_run     <= 1'b1;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 16'd0;
      led_loading <= 1'b0;
      err_flag    <= 1'b0;
      low_byte    <= 8'd0;
      index       <= 16'd0;
      skid_valid  <= 1'b0;
      skid_data   <= 8'd0;
      to_cnt      <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      if (start_req) begin
        state       <= S_CNT_L;
        cpu_run     <= 1'b0;
        led_loading <= 1'b1;
        err_flag    <= 1'b0;
        to_cnt      <= 32'd0;
        skid_valid  <= 1'b0;
      end else begin
        case (state)
          S_RUN: cpu_run <= 1'b1;

          S_CNT_L, S_CNT_H, S_INS_L, S_INS_H: begin
            if (in_valid) begin
              // If the skid byte is consumed while a new byte arrives, park the new one.
              skid_valid <= skid_valid & rx_valid;
              skid_data  <= rx_data;
              to_cnt     <= 32'd0;
              case (state)
                S_CNT_L: begin
                  low_byte <= in_data;
                  state    <= S_CNT_H;
                end
                S_CNT_H: begin
                  count_q <= {in_data, low_byte};
                  if ({in_data, low_byte} == 16'd0) begin
                    state       <= S_DONE;
                    led_loading <= 1'b0;
                  end else begin
                    state <= S_INS_L;
                    index <= 16'd0;
                  end
                end
                S_INS_L: begin
                  low_byte <= in_data;
                  state    <= S_INS_H;
                end
                S_INS_H: begin
                  state <= S_WRITE;
                  if ({1'b0, index} < DEPTH17) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= index[ADDR_W-1:0];
                    imem_wdata <= {in_data, low_byte};
                  end else begin
                    // Overflow words are consumed but not written to keep framing.
                    err_flag <= 1'b1;
                  end
                end
                default: state <= S_RUN;
              endcase
            end else if (to_cnt >= TO_LIM) begin
              state       <= S_ERR;
              led_loading <= 1'b0;
              err_flag    <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 32'd1;
            end
          end

          S_WRITE: begin
            if (rx_valid) begin
              skid_valid <= 1'b1;
              skid_data  <= rx_data;
              to_cnt     <= 32'd0;
            end
            index <= index + 16'd1;
            if (index + 16'd1 == count_q) begin
              state       <= S_DONE;
              led_loading <= 1'b0;
            end else begin
              state <= S_INS_L;
            end
          end

          S_DONE: cpu_run <= 1'b0;

          S_ERR: cpu_run <= 1'b0;

          default: state <= S_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - scoreboard bench for uart_program_loader
module tb_uart_program_loader;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        wait_transport = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;

  logic        a_we, a_run, a_led, a_err;
  logic [7:0]  a_addr;
  logic [15:0] a_wdata, a_cnt;
  logic        b_we, b_run, b_led, b_err;
  logic [1:0]  b_addr;
  logic [15:0] b_wdata, b_cnt;

  int checks = 0;
  int failures = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 CLK = ~CLK;

  uart_program_loader #(.ADDR_W(8), .TIMEOUT_CYC(100)) dut_a (
    .CLK(CLK), .RESET(RESET), .wait_transport(wait_transport),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .cpu_run(a_run), .led_loading(a_led), .err_flag(a_err), .loaded_count(a_cnt)
  );

  uart_program_loader #(.ADDR_W(2), .TIMEOUT_CYC(100)) dut_b (
    .CLK(CLK), .RESET(RESET), .wait_transport(wait_transport),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .cpu_run(b_run), .led_loading(b_led), .err_flag(b_err), .loaded_count(b_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Write monitor: every imem_we pulse must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (a_we === 1'b1) begin
      if (qa.size() == 0) check("a_unexpected_write", {8'd0, a_addr, a_wdata}, 32'hFFFF_FFFF);
      else check("a_write", {8'd0, a_addr, a_wdata}, qa.pop_front());
    end
    if (b_we === 1'b1) begin
      if (qb.size() == 0) check("b_unexpected_write", {14'd0, b_addr, b_wdata}, 32'hFFFF_FFFF);
      else check("b_write", {14'd0, b_addr, b_wdata}, qb.pop_front());
    end
  end

  task automatic expect_a(input int addr, input logic [15:0] d);
    qa.push_back({16'(addr), d});
  endtask
  task automatic expect_b(input int addr, input logic [15:0] d);
    qb.push_back({16'(addr), d});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge CLK); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge CLK); #1;
    rx_valid = 1'b0;
    idle(gap);
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    send_byte(w[7:0], 1);
    send_byte(w[15:8], gap);
  endtask

  task automatic start_load;
    @(posedge CLK); #1;
    wait_transport = 1'b0;
    @(posedge CLK); #1;
    wait_transport = 1'b1;
  endtask

  task automatic pulse_reset;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
  endtask

  task automatic check_both(input string name, input logic led, input logic run, input logic err);
    @(negedge CLK);
    check({name, "_a_led"}, {31'd0, a_led}, {31'd0, led});
    check({name, "_a_run"}, {31'd0, a_run}, {31'd0, run});
    check({name, "_a_err"}, {31'd0, a_err}, {31'd0, err});
    check({name, "_b_led"}, {31'd0, b_led}, {31'd0, led});
    check({name, "_b_run"}, {31'd0, b_run}, {31'd0, run});
    check({name, "_b_err"}, {31'd0, b_err}, {31'd0, err});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    idle(3);
    @(negedge CLK);
    check("reset_we", {31'd0, a_we}, 32'd0);
    check("reset_addr", {24'd0, a_addr}, 32'd0);
    check("reset_cnt", {16'd0, a_cnt}, 32'd0);
    check_both("reset", 1'b0, 1'b1, 1'b0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    idle(2);

    // Three-word load.
    start_load();
    check_both("t1_start", 1'b1, 1'b0, 1'b0);
    expect_a(0, 16'h1234); expect_a(1, 16'hABCD); expect_a(2, 16'h0F0F);
    expect_b(0, 16'h1234); expect_b(1, 16'hABCD); expect_b(2, 16'h0F0F);
    send_word(16'd3, 2);
    send_word(16'h1234, 2);
    send_word(16'hABCD, 2);
    check_both("t1_mid", 1'b1, 1'b0, 1'b0);
    send_word(16'h0F0F, 2);
    check_both("t1_done", 1'b0, 1'b0, 1'b0);
    check("t1_cnt", {16'd0, a_cnt}, 32'd3);
    idle(5);
    check_both("t1_hold", 1'b0, 1'b0, 1'b0);
    pulse_reset();
    check_both("t1_reset", 1'b0, 1'b1, 1'b0);
    check("t1_cnt_kept", {16'd0, a_cnt}, 32'd3);
    idle(3);

    // Zero-length load.
    start_load();
    send_word(16'd0, 2);
    check_both("t2_done", 1'b0, 1'b0, 1'b0);
    check("t2_cnt", {16'd0, b_cnt}, 32'd0);
    pulse_reset();
    idle(3);

    // Six words: dut_b (depth 4) overflows on the fifth word.
    start_load();
    send_word(16'd6, 2);
    for (int i = 0; i < 6; i++) begin
      w = 16'h1000 + 16'(i * 16'h0111);
      expect_a(i, w);
      if (i < 4) expect_b(i, w);
    end
    for (int i = 0; i < 6; i++) begin
      w = 16'h1000 + 16'(i * 16'h0111);
      send_word(w, 2);
      @(negedge CLK);
      if (i == 3) check("t3_b_err_w4", {31'd0, b_err}, 32'd0);
      if (i == 4) begin
        check("t3_b_err_w5", {31'd0, b_err}, 32'd1);
        check("t3_a_err_w5", {31'd0, a_err}, 32'd0);
        check("t3_b_led_w5", {31'd0, b_led}, 32'd1);
      end
    end
    check("t3_b_err", {31'd0, b_err}, 32'd1);
    check("t3_b_led", {31'd0, b_led}, 32'd0);
    check("t3_a_led", {31'd0, a_led}, 32'd0);
    check("t3_b_cnt", {16'd0, b_cnt}, 32'd6);
    pulse_reset();
    check_both("t3_reset", 1'b0, 1'b1, 1'b0);
    idle(3);

    // Timeout after the count LSB, then a clean restart.
    start_load();
    send_byte(8'h02, 0);
    idle(50);
    check_both("t4_wait", 1'b1, 1'b0, 1'b0);
    idle(70);
    check_both("t4_err", 1'b0, 1'b0, 1'b1);
    start_load();
    check_both("t4_restart", 1'b1, 1'b0, 1'b0);
    expect_a(0, 16'hBEEF); expect_a(1, 16'h5A5A);
    expect_b(0, 16'hBEEF); expect_b(1, 16'h5A5A);
    send_word(16'd2, 2);
    send_word(16'hBEEF, 2);
    send_word(16'h5A5A, 2);
    check_both("t4_done", 1'b0, 1'b0, 1'b0);
    check("t4_cnt", {16'd0, a_cnt}, 32'd2);
    pulse_reset();
    idle(3);

    // RESET in the middle of a four-word load.
    start_load();
    expect_a(0, 16'h1111); expect_a(1, 16'h2222);
    expect_b(0, 16'h1111); expect_b(1, 16'h2222);
    send_word(16'd4, 2);
    send_word(16'h1111, 2);
    send_word(16'h2222, 2);
    pulse_reset();
    check_both("t5_reset", 1'b0, 1'b1, 1'b0);
    check("t5_cnt", {16'd0, a_cnt}, 32'd4);
    check("t5_q_a", qa.size(), 32'd0);
    idle(10);

    // Next LSB arrives on the exact WRITE cycle.
    start_load();
    expect_a(0, 16'h3344); expect_a(1, 16'h7788);
    expect_b(0, 16'h3344); expect_b(1, 16'h7788);
    send_word(16'd2, 2);
    send_byte(8'h44, 1);
    @(posedge CLK); #1;
    rx_valid = 1'b1; rx_data = 8'h33;
    @(posedge CLK); #1;
    rx_data = 8'h88;
    @(posedge CLK); #1;
    rx_valid = 1'b0;
    idle(2);
    send_byte(8'h77, 2);
    check_both("t6_done", 1'b0, 1'b0, 1'b0);
    check("t6_cnt", {16'd0, a_cnt}, 32'd2);

    idle(5);
    check("final_q_a", qa.size(), 32'd0);
    check("final_q_b", qb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Sequences program download from the UART receiver into instruction memory.
- Owns the CPU run/hold control: holds the CPU paused while a program is being received, then releases it on the next RESET.
- Sits between the UART RX byte interface, the instruction-memory write port, and the CPU core's run-enable and LED status outputs.
- Wire format: a 16-bit instruction count, then that many 16-bit instructions. Every word is sent as two bytes, LSB first.

Parameters:
- ADDR_W, 8: instruction-memory address width. Capacity is DEPTH = 2**ADDR_W words.
- TIMEOUT_CYC, 1000000: maximum number of CLK cycles allowed between consecutive bytes while a load is in progress.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RESET  in  1  synchronous, active-low reset (physical button).
- wait_transport  in  1  active-low load request (physical button). Sampled level-low.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received UART byte.
- imem_we  out  1  instruction-memory write strobe, one cycle wide.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  16  write data.
- cpu_run  out  1  1 = CPU clocks its PC; 0 = CPU held at PC 0.
- led_loading  out  1  1 while in any load state (drives led4).
- err_flag  out  1  sticky error: overflow or timeout.
- loaded_count  out  16  instruction count received in the last load.

Behaviour:
- One clock domain, CLK. RESET is synchronous and active-low.
- RESET low, on a CLK edge:
  - state=RUN, cpu_run=1, imem_we=0, imem_addr=0, imem_wdata=0, led_loading=0, err_flag=0.
  - loaded_count is NOT cleared; it keeps the last value (0 after configuration, via initial value).
  - Instruction memory contents are untouched.
  - RESET mid-load aborts the load and enters RUN; partially written words remain in memory.
- States: RUN, CNT_L, CNT_H, INS_L, INS_H, WRITE, DONE, ERR.
- RUN:
  - cpu_run=1.
  - wait_transport==0 -> CNT_L; cpu_run=0 from the next cycle; led_loading=1; err_flag cleared; timeout counter cleared.
- CNT_L: rx_valid -> latch the count low byte -> CNT_H.
- CNT_H: rx_valid -> latch the count high byte into loaded_count.
  - count==0 -> DONE.
  - otherwise -> INS_L, with the word index cleared to 0.
- INS_L: rx_valid -> latch the data low byte -> INS_H.
- INS_H: rx_valid -> assemble {rx_data, low} -> WRITE.
- WRITE (exactly one cycle):
  - If index < DEPTH: imem_we=1, imem_addr=index[ADDR_W-1:0], imem_wdata=word.
  - If index >= DEPTH: imem_we stays 0 and err_flag is set; the words are still consumed so framing is preserved.
  - index increments. If index+1 == count -> DONE, else -> INS_L.
  - Latency: imem_we asserts on the cycle after the rx_valid that carries the MSB.
- rx_valid arriving in WRITE is not dropped: it is held in a one-byte skid register and consumed in INS_L on the next cycle.
- DONE: cpu_run=0, led_loading=0. Stays here until RESET low (-> RUN). wait_transport low in DONE starts a new load (-> CNT_L).
- Timeout:
  - Counter runs in CNT_L..INS_H and clears on every rx_valid.
  - Reaching TIMEOUT_CYC -> ERR.
  - ERR: cpu_run=0, led_loading=0, err_flag=1. Exits only on RESET or on wait_transport low (-> CNT_L).
- wait_transport low while already loading is ignored; no restart.
- Arithmetic:
  - The index is 16-bit and compared against the full 16-bit count.
  - Address is index truncated to ADDR_W bits. No wrap-around writes: writes beyond DEPTH are suppressed.
- Outputs are registered. imem_we is never high outside WRITE.

Test Plan:
- Count 3, words 0x1234, 0xABCD, 0x0F0F -> three imem_we pulses at addresses 0, 1, 2 with matching data; led_loading drops at the DONE transition; cpu_run stays 0 until RESET is pulsed, then becomes 1; loaded_count=3.
- Count 0 -> DONE immediately after the second byte; no imem_we; err_flag=0.
- ADDR_W=2, count 6 -> writes only at addresses 0..3; err_flag=1 after the fifth word; DONE after all 12 data bytes.
- Stall after the count LSB for more than TIMEOUT_CYC (bench sets it to 100) -> ERR, err_flag=1, led_loading=0; a wait_transport pulse then restarts a load cleanly.
- RESET pulsed after the second instruction of a 4-word load -> RUN, cpu_run=1, err_flag=0; words 0 and 1 remain in memory.
- rx_valid asserted on the exact cycle of WRITE (back-to-back bytes) -> no byte lost; next word's data correct.
